// File: rtl/score4_win_checker.sv
// score4_win_checker: scans a snapshot of the 6x7 score4 panel for four-in-a-line.
// A start pulse in IDLE captures the panel. The scan then visits one anchor cell
// per cycle in row-major order and tests four directions from each anchor.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - scan request, sampled only in IDLE
//   panel      - live panel, 2 bits per cell (01 = A, 10 = B, 00/11 = empty)
//   busy       - high while in SCAN or DONE
//   done       - one-cycle pulse when the results become valid
//   win_a      - player A has at least one line
//   win_b      - player B has at least one line
//   full_panel - every cell holds 01 or 10
//   win_row    - anchor row of the first line found
//   win_col    - anchor column of the first line found
//   win_dir    - direction of that line (0 +col, 1 +row, 2 +row+col, 3 +row-col)
module score4_win_checker #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ROWS-1:0][COLS-1:0][1:0] panel,
    output logic                          busy,
    output logic                          done,
    output logic                          win_a,
    output logic                          win_b,
    output logic                          full_panel,
    output logic [2:0]                    win_row,
    output logic [2:0]                    win_col,
    output logic [1:0]                    win_dir
);

    localparam int unsigned ROW_W = 3;
    localparam int unsigned COL_W = 3;
    localparam int unsigned DIR_W = 2;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned N_DIR = 4;
    localparam int          CELLS = ROWS * COLS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic [ROWS-1:0][COLS-1:0][1:0] panel_t;

    // Registered state
    state_t             state;
    panel_t             snap;
    logic [ROW_W-1:0]   row_idx;
    logic [COL_W-1:0]   col_idx;
    logic [CNT_W-1:0]   cnt;
    logic               found;

    // Next-state values
    state_t             state_n;
    panel_t             snap_n;
    logic [ROW_W-1:0]   row_idx_n;
    logic [COL_W-1:0]   col_idx_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               found_n;
    logic               busy_n;
    logic               done_n;
    logic               win_a_n;
    logic               win_b_n;
    logic               full_panel_n;
    logic [ROW_W-1:0]   win_row_n;
    logic [COL_W-1:0]   win_col_n;
    logic [DIR_W-1:0]   win_dir_n;

    // Anchor evaluation
    logic [1:0]         anchor;
    logic               anchor_valid;
    logic [N_DIR-1:0]   in_bounds;
    logic [N_DIR-1:0]   match;
    logic [DIR_W-1:0]   first_dir;
    logic               last_anchor;
    logic               line_ok;
    int                 probe_row;
    int                 probe_col;

    // Row step per direction: only horizontal stays on the anchor row.
    function automatic int row_step(input int dir);
        row_step = (dir == 0) ? 0 : 1;
    endfunction

    // Column step per direction.
    function automatic int col_step(input int dir);
        case (dir)
            0:       col_step = 1;
            1:       col_step = 0;
            2:       col_step = 1;
            default: col_step = -1;
        endcase
    endfunction

    // Off-panel coordinates read as empty so they can never extend a line.
    function automatic logic [1:0] cell_at(input panel_t p, input int r, input int c);
        cell_at = 2'b00;
        if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
            cell_at = p[ROW_W'(r)][COL_W'(c)];
        end
    endfunction

    // Line tests for the current anchor in all four directions.
    always_comb begin : anchor_eval
        anchor       = snap[row_idx][col_idx];
        anchor_valid = (anchor == 2'b01) || (anchor == 2'b10);
        in_bounds[0] = int'(col_idx) <= COLS - WIN_LEN;
        in_bounds[1] = int'(row_idx) <= ROWS - WIN_LEN;
        in_bounds[2] = in_bounds[0] && in_bounds[1];
        in_bounds[3] = in_bounds[1] && (int'(col_idx) >= WIN_LEN - 1);
        match        = '0;
        line_ok      = 1'b0;
        probe_row    = 0;
        probe_col    = 0;
        for (int d = 0; d < int'(N_DIR); d++) begin
            line_ok = anchor_valid && in_bounds[2'(d)];
            for (int k = 1; k < WIN_LEN; k++) begin
                probe_row = int'(row_idx) + k * row_step(d);
                probe_col = int'(col_idx) + k * col_step(d);
                if (cell_at(snap, probe_row, probe_col) != anchor) begin
                    line_ok = 1'b0;
                end
            end
            match[2'(d)] = line_ok;
        end
    end

    // Lowest-numbered matching direction takes priority at one anchor.
    always_comb begin : dir_priority
        first_dir = '0;
        for (int d = int'(N_DIR) - 1; d >= 0; d--) begin
            if (match[2'(d)]) begin
                first_dir = DIR_W'(d);
            end
        end
    end

    assign last_anchor = (row_idx == ROW_W'(ROWS - 1)) && (col_idx == COL_W'(COLS - 1));

    // Next-state and next-output logic.
    always_comb begin : next_logic
        state_n      = state;
        snap_n       = snap;
        row_idx_n    = row_idx;
        col_idx_n    = col_idx;
        cnt_n        = cnt;
        found_n      = found;
        done_n       = 1'b0;
        win_a_n      = win_a;
        win_b_n      = win_b;
        full_panel_n = full_panel;
        win_row_n    = win_row;
        win_col_n    = win_col;
        win_dir_n    = win_dir;

        case (state)
            S_IDLE: begin
                if (start) begin
                    snap_n       = panel;
                    win_a_n      = 1'b0;
                    win_b_n      = 1'b0;
                    full_panel_n = 1'b0;
                    win_row_n    = '0;
                    win_col_n    = '0;
                    win_dir_n    = '0;
                    cnt_n        = '0;
                    found_n      = 1'b0;
                    row_idx_n    = '0;
                    col_idx_n    = '0;
                    state_n      = S_SCAN;
                end
            end

            S_SCAN: begin
                if (anchor_valid) begin
                    cnt_n = cnt + CNT_W'(1);
                end
                if (|match) begin
                    if (anchor == 2'b01) begin
                        win_a_n = 1'b1;
                    end else begin
                        win_b_n = 1'b1;
                    end
                    // Only the first line of the scan is reported for highlighting.
                    if (!found) begin
                        found_n   = 1'b1;
                        win_row_n = row_idx;
                        win_col_n = col_idx;
                        win_dir_n = first_dir;
                    end
                end
                if (last_anchor) begin
                    full_panel_n = (cnt_n == CNT_W'(CELLS));
                    done_n       = 1'b1;
                    state_n      = S_DONE;
                end else if (col_idx == COL_W'(COLS - 1)) begin
                    col_idx_n = '0;
                    row_idx_n = row_idx + ROW_W'(1);
                end else begin
                    col_idx_n = col_idx + COL_W'(1);
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            snap       <= '0;
            row_idx    <= '0;
            col_idx    <= '0;
            cnt        <= '0;
            found      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            win_a      <= 1'b0;
            win_b      <= 1'b0;
            full_panel <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            win_dir    <= '0;
        end else begin
            state      <= state_n;
            snap       <= snap_n;
            row_idx    <= row_idx_n;
            col_idx    <= col_idx_n;
            cnt        <= cnt_n;
            found      <= found_n;
            busy       <= busy_n;
            done       <= done_n;
            win_a      <= win_a_n;
            win_b      <= win_b_n;
            full_panel <= full_panel_n;
            win_row    <= win_row_n;
            win_col    <= win_col_n;
            win_dir    <= win_dir_n;
        end
    end

endmodule

// File: doc/score4_win_checker.md
Name: score4_win_checker

Overview:
- Read-side counterpart of the score4 game-state updater. The updater writes the 6x7 panel; this block reads it and produces the win_a, win_b and full_panel status that the updater consumes.
- On a start pulse it snapshots the panel, then scans it one anchor cell per cycle for four-in-a-line in four directions.
- It reports the result with a one-cycle done pulse and sticky result flags. It also returns the first winning line found, for display highlighting.

Parameters:
- ROWS, 6, panel rows; row 0 is the bottom row and fills first.
- COLS, 7, panel columns.
- WIN_LEN, 4, number of equal cells in a line that constitutes a win.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request a scan; sampled only in IDLE.
- panel  in  2 x [ROWS][COLS]  cell encoding: 00 empty, 01 player A (turn 0), 10 player B (turn 1), 11 treated as empty.
- busy  out  1  high while in SCAN or DONE.
- done  out  1  one-cycle pulse when results become valid.
- win_a  out  1  A has at least one line.
- win_b  out  1  B has at least one line.
- full_panel  out  1  all ROWS*COLS cells are 01 or 10.
- win_row  out  3  anchor row of the first line found.
- win_col  out  3  anchor column of the first line found.
- win_dir  out  2  direction of that line: 0 horizontal (+col), 1 vertical (+row), 2 diagonal (+row,+col), 3 anti-diagonal (+row,-col).

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - All outputs 0; snapshot, index and counters 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE with start=1, at that edge:
  - Register the full panel into the snapshot.
  - Clear win_a, win_b, full_panel, win_row, win_col, win_dir, the cell count and the found flag.
  - Set r=0, c=0; go to SCAN.
- SCAN: one anchor (r,c) per edge, row-major order (c increments; at COLS-1, wrap c=0 and r++).
  - Let v = snap[r][c]. If v is 01 or 10, test every direction whose WIN_LEN-1 further cells lie in bounds:
    - dir 0: c <= COLS-WIN_LEN.
    - dir 1: r <= ROWS-WIN_LEN.
    - dir 2: both conditions above.
    - dir 3: r <= ROWS-WIN_LEN and c >= WIN_LEN-1.
  - Out-of-bounds directions never match.
  - A direction matches if all WIN_LEN cells equal v. Any match sets win_a (v=01) or win_b (v=10).
  - The first match of the whole scan latches win_row/col/dir and sets found. On several matches at one anchor, the lowest dir number wins. Later matches never overwrite.
  - The nonempty cell count (6 bits) increments for each 01/10 anchor.
- Last anchor (r=ROWS-1, c=COLS-1):
  - At the edge that evaluates it, its own matches and count are included.
  - full_panel <= (final count == ROWS*COLS); done <= 1; go to DONE.
- DONE: next edge sets done <= 0 and returns to IDLE. start is ignored in DONE.
- Latency:
  - done is high in the cycle following the 42nd edge after the edge that sampled start.
  - One full scan occupies 43 edges from start sample to return to IDLE.
- Result outputs hold their values until the next accepted start clears them.
- Boundary conditions:
  - start during SCAN or DONE: ignored, no restart.
  - start held high: a new scan begins on the edge after returning to IDLE.
  - panel input changing after the start edge: no effect (snapshot).
  - Both colours have lines: win_a=win_b=1; the coordinates belong to the first in scan order.
  - 11 cells: treated as empty, not counted, never match.
  - Reset mid-scan: immediately IDLE, all outputs 0.

Test Plan:
- Reset asserted mid-scan (edge 20) -> busy, done and all flags 0 immediately. A later start completes a normal 43-edge scan.
- All-empty panel, start pulse -> busy high for 43 cycles, done pulses exactly once 42 edges after start; win_a=win_b=full_panel=0.
- A at row 0, cols 3..6 -> win_a=1, win_b=0, win_row=0, win_col=3, win_dir=0.
- B at (0,6),(1,5),(2,4),(3,3), plus A vertical at col 0 rows 2..5 -> win_a=win_b=1, win_row=0, win_col=6, win_dir=3 (B anchor precedes A anchor (2,0)).
- Full 42-cell panel with no line, checked against a bench reference model -> full_panel=1, win_a=win_b=0. Repeating with one cell 11 -> full_panel=0.
- Start a scan, then change panel and pulse start at edge 10 -> start ignored, results reflect the original snapshot, and exactly one done pulse.
